// File: rtl/code_pkg.sv
// Shared definitions for the BCD self-complementing encoder.
// The table is a shifted BCD code: 0..4 add two, 5..9 add four, so
// code(9-d) is always the bitwise inverse of code(d).
package code_pkg;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] CODE_0 = 4'b0010;
    localparam logic [CODE_W-1:0] CODE_1 = 4'b0011;
    localparam logic [CODE_W-1:0] CODE_2 = 4'b0100;
    localparam logic [CODE_W-1:0] CODE_3 = 4'b0101;
    localparam logic [CODE_W-1:0] CODE_4 = 4'b0110;
    localparam logic [CODE_W-1:0] CODE_5 = 4'b1001;
    localparam logic [CODE_W-1:0] CODE_6 = 4'b1010;
    localparam logic [CODE_W-1:0] CODE_7 = 4'b1011;
    localparam logic [CODE_W-1:0] CODE_8 = 4'b1100;
    localparam logic [CODE_W-1:0] CODE_9 = 4'b1101;

    // A digit is legal BCD when it is 0..9.
    function automatic logic is_legal(input logic [3:0] digit);
        return (digit <= 4'd9);
    endfunction

    // Digit-to-code lookup; illegal digits return zero and are never stored.
    function automatic logic [CODE_W-1:0] encode_digit(input logic [3:0] digit);
        logic [CODE_W-1:0] code;
        case (digit)
            4'd0:    code = CODE_0;
            4'd1:    code = CODE_1;
            4'd2:    code = CODE_2;
            4'd3:    code = CODE_3;
            4'd4:    code = CODE_4;
            4'd5:    code = CODE_5;
            4'd6:    code = CODE_6;
            4'd7:    code = CODE_7;
            4'd8:    code = CODE_8;
            4'd9:    code = CODE_9;
            default: code = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Small synchronous FIFO holding encoded words.
// The head is presented combinationally so a word written on one edge is
// visible right after that edge; the output reads zero while empty.
module code_fifo
    import code_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CODE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_reg == LEVEL_FULL);
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    // Writes into a full FIFO and reads from an empty one are ignored here,
    // so callers may hold push/pop high without guarding them.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    // Storage array: write only, no reset, so it maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + (PTR_W+1)'(1);
                2'b01:   level_reg <= level_reg - (PTR_W+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/code_encoder.sv
// BCD digit encoder with an output FIFO.
// Legal digits are encoded on the way into the FIFO; illegal digits are
// accepted, discarded and flagged with a one-cycle err pulse.
module code_encoder
    import code_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               d,
    input  logic                     d_valid,
    output logic                     d_ready,
    output logic [CODE_W-1:0]        C,
    output logic                     c_valid,
    input  logic                     c_ready,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level
);

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              digit_legal;
    logic              fifo_push;
    logic [CODE_W-1:0] code_word;
    logic              err_reg;

    // Readiness depends only on occupancy, never on the consumer side.
    assign d_ready     = !fifo_full;
    assign accept      = d_valid && d_ready;
    assign digit_legal = is_legal(d);
    assign fifo_push   = accept && digit_legal;
    assign code_word   = encode_digit(d);
    assign c_valid     = !fifo_empty;
    assign err         = err_reg;

    code_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (code_word),
        .pop   (c_ready),
        .dout  (C),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Flag an accepted illegal digit for exactly the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= accept && !digit_legal;
        end
    end

endmodule

// File: tb/tb_code_encoder.sv
// Scoreboard bench for code_encoder: the driver pushes expected codes when a
// digit is accepted, an independent negedge monitor pops and compares.
module tb_code_encoder;
    import code_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    d = 4'd0;
    logic          d_valid = 1'b0;
    logic          c_ready = 1'b0;
    logic          d_ready;
    logic [3:0]    C;
    logic          c_valid;
    logic          err;
    logic [LW-1:0] level;

    logic [3:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    bit         mon_en = 1'b0;
    bit         err_exp = 1'b0;

    code_encoder #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .C       (C),
        .c_valid (c_valid),
        .c_ready (c_ready),
        .err     (err),
        .level   (level)
    );

    always #5 clk = ~clk;

    // Reference code computed arithmetically from the digit value.
    function automatic logic [3:0] model_code(input int dig);
        return 4'((dig < 5) ? dig + 2 : dig + 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; starts just after a rising edge, ends 1 unit after the next.
    task automatic step(input bit v, input int dig, input bit cr);
        bit acc;
        d_valid = v;
        d       = 4'(dig);
        c_ready = cr;
        acc     = v && (exp_q.size() < DEPTH) && (dig <= 9);
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(model_code(dig));
        $display("step v=%0d d=%0d c_ready=%0d accepted_legal=%0d level=%0d", v, dig, cr, acc, level);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && exp_q.size() > 0; i++) step(1'b0, 0, 1'b1);
        check("drain_level", 32'(level), 32'd0);
    endtask

    // Monitor: compares outputs against the scoreboard and pops on transfers.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            int sz;
            sz = exp_q.size();
            check("level", 32'(level), 32'(sz));
            check("c_valid", 32'(c_valid), 32'(sz > 0));
            check("d_ready", 32'(d_ready), 32'(sz < DEPTH));
            check("err", 32'(err), 32'(err_exp));
            if (sz > 0) check("C_head", 32'(C), 32'(exp_q[0]));
            else        check("C_empty", 32'(C), 32'd0);
            err_exp = d_valid && (sz < DEPTH) && (d > 4'd9);
            if (c_ready && sz > 0) begin
                $display("pop C=%b", exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset values while rst_n is low
        #2;
        check("rst_level", 32'(level), 32'd0);
        check("rst_c_valid", 32'(c_valid), 32'd0);
        check("rst_C", 32'(C), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd1);
        #10;
        rst_n  = 1'b1;   // t=12, first edge at t=15 must already transfer
        mon_en = 1'b1;

        // All ten digits in order with the consumer always ready
        for (int i = 0; i <= 9; i++) begin
            step(1'b1, i, 1'b1);
            check("latency_C", 32'(C), 32'(model_code(i)));
        end
        drain();

        // Backpressure: five offers into a 4-deep FIFO
        for (int i = 0; i < 5; i++) step(1'b1, i + 3, 1'b0);
        check("full_level", 32'(level), 32'(DEPTH));
        check("full_d_ready", 32'(d_ready), 32'd0);
        step(1'b1, 2, 1'b1);   // full with c_ready=1: no write this edge
        check("full_pop_level", 32'(level), 32'(DEPTH - 1));
        drain();

        // Illegal digits are dropped with an err pulse each
        step(1'b1, 10, 1'b1);
        check("ill_err1", 32'(err), 32'd1);
        step(1'b1, 15, 1'b1);
        check("ill_err2", 32'(err), 32'd1);
        step(1'b0, 0, 1'b1);
        check("ill_err_clear", 32'(err), 32'd0);
        check("ill_level", 32'(level), 32'd0);

        // Simultaneous push/pop at level 2 across pointer wrap
        step(1'b1, 1, 1'b0);
        step(1'b1, 8, 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step(1'b1, int'($urandom_range(9, 0)), 1'b1);
            check("pushpop_level", 32'(level), 32'd2);
        end
        // Illegal push with pop: level drops by one
        step(1'b1, 12, 1'b1);
        check("ill_pop_level", 32'(level), 32'd1);
        check("ill_pop_err", 32'(err), 32'd1);
        drain();

        // Self-complement property of the code table
        for (int i = 0; i <= 9; i++) begin
            check("complement", 32'(encode_digit(4'(i)) ^ encode_digit(4'(9 - i))), 32'hF);
            check("table", 32'(encode_digit(4'(i))), 32'(model_code(i)));
        end

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, i + 5, 1'b0);
        check("pre_rst_level", 32'(level), 32'd3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        err_exp = 1'b0;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_c_valid", 32'(c_valid), 32'd0);
        check("arst_C", 32'(C), 32'd0);
        check("arst_d_ready", 32'(d_ready), 32'd1);
        check("arst_err", 32'(err), 32'd0);
        d_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 4, 1'b1);
        check("post_rst_C", 32'(C), 32'b0110);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), 1'($urandom_range(3, 0) != 0));
        end
        drain();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case something stalls the driver.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
